// File: rtl/sa2_host.sv
// Host-side driver for the 2x2 systolic convolution array: loads 16 data and 9 filter bytes,
// clears and runs the array, captures c11..c22 and streams them out over valid/ready.
module sa2_host #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       err,
  output logic       sa_clr,
  output logic       active_sa2,
  input  logic       done_sa2,
  output logic [7:0] a11, a12, a13, a14,
  output logic [7:0] a21, a22, a23, a24,
  output logic [7:0] a31, a32, a33, a34,
  output logic [7:0] a41, a42, a43, a44,
  output logic [7:0] b11, b12, b13,
  output logic [7:0] b21, b22, b23,
  output logic [7:0] b31, b32, b33,
  input  logic [7:0] c11, c12, c21, c22
);

  typedef enum logic [1:0] {StLoad, StClr, StRun, StDrain} state_e;

  localparam logic [7:0] RunLast = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [4:0] ld_cnt_q, ld_cnt_d;
  logic [7:0] run_cnt_q, run_cnt_d;
  logic [1:0] rd_idx_q, rd_idx_d;
  logic       sa_clr_q, sa_clr_d;
  logic       active_q, active_d;
  logic       err_q, err_d;
  logic       ld_we, capture;
  logic [4:0] b_idx;
  logic [7:0] a_q [16];
  logic [7:0] b_q [9];
  logic [7:0] res_q [4];

  assign b_idx = ld_cnt_q - 5'd16;

  always_comb begin
    state_d   = state_q;
    ld_cnt_d  = ld_cnt_q;
    run_cnt_d = run_cnt_q;
    rd_idx_d  = rd_idx_q;
    sa_clr_d  = 1'b0;
    active_d  = 1'b0;
    err_d     = 1'b0;
    ld_we     = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (in_valid) begin
          ld_we = 1'b1;
          if (ld_cnt_q == 5'd24) begin
            ld_cnt_d = 5'd0;
            state_d  = StClr;
            sa_clr_d = 1'b1;
          end else begin
            ld_cnt_d = ld_cnt_q + 5'd1;
          end
        end
      end
      StClr: begin
        state_d   = StRun;
        active_d  = 1'b1;
        run_cnt_d = 8'd0;
      end
      StRun: begin
        // Completion takes priority over a coincident timeout.
        if (done_sa2) begin
          capture = 1'b1;
          state_d = StDrain;
        end else if (run_cnt_q == RunLast) begin
          err_d   = 1'b1;
          state_d = StLoad;
        end else begin
          active_d  = 1'b1;
          run_cnt_d = run_cnt_q + 8'd1;
        end
      end
      StDrain: begin
        if (out_ready) begin
          if (rd_idx_q == 2'd3) begin
            rd_idx_d = 2'd0;
            state_d  = StLoad;
          end else begin
            rd_idx_d = rd_idx_q + 2'd1;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StLoad;
      ld_cnt_q  <= 5'd0;
      run_cnt_q <= 8'd0;
      rd_idx_q  <= 2'd0;
      sa_clr_q  <= 1'b0;
      active_q  <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < 16; i++) a_q[i] <= 8'h00;
      for (int i = 0; i < 9; i++) b_q[i] <= 8'h00;
      for (int i = 0; i < 4; i++) res_q[i] <= 8'h00;
    end else begin
      state_q   <= state_d;
      ld_cnt_q  <= ld_cnt_d;
      run_cnt_q <= run_cnt_d;
      rd_idx_q  <= rd_idx_d;
      sa_clr_q  <= sa_clr_d;
      active_q  <= active_d;
      err_q     <= err_d;
      if (ld_we) begin
        if (ld_cnt_q < 5'd16) a_q[ld_cnt_q[3:0]] <= in_data;
        else                  b_q[b_idx[3:0]]    <= in_data;
      end
      if (capture) begin
        res_q[0] <= c11;
        res_q[1] <= c12;
        res_q[2] <= c21;
        res_q[3] <= c22;
      end
    end
  end

  assign in_ready   = (state_q == StLoad);
  assign out_valid  = (state_q == StDrain);
  assign out_last   = (state_q == StDrain) && (rd_idx_q == 2'd3);
  assign out_data   = (state_q == StDrain) ? res_q[rd_idx_q] : 8'h00;
  assign err        = err_q;
  assign sa_clr     = sa_clr_q;
  assign active_sa2 = active_q;

  assign a11 = a_q[0];  assign a12 = a_q[1];  assign a13 = a_q[2];  assign a14 = a_q[3];
  assign a21 = a_q[4];  assign a22 = a_q[5];  assign a23 = a_q[6];  assign a24 = a_q[7];
  assign a31 = a_q[8];  assign a32 = a_q[9];  assign a33 = a_q[10]; assign a34 = a_q[11];
  assign a41 = a_q[12]; assign a42 = a_q[13]; assign a43 = a_q[14]; assign a44 = a_q[15];
  assign b11 = b_q[0];  assign b12 = b_q[1];  assign b13 = b_q[2];
  assign b21 = b_q[3];  assign b22 = b_q[4];  assign b23 = b_q[5];
  assign b31 = b_q[6];  assign b32 = b_q[7];  assign b33 = b_q[8];

endmodule

// File: tb/tb_sa2_host.sv
// Bench for sa2_host: two instances (default TIMEOUT and TIMEOUT=29) driven with the same
// byte stream, each with its own behavioural array stub; results checked against a byte model.
module tb_sa2_host;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b1;
  logic [7:0] c_val [4];

  logic       in_ready1, out_valid1, out_last1, err1, sa_clr1, act1, done1;
  logic       in_ready2, out_valid2, out_last2, err2, sa_clr2, act2, done2;
  logic [7:0] out_data1, out_data2;
  logic [7:0] op1 [25];
  logic [7:0] op2 [25];

  // Array stubs: done for one cycle when the N-th active cycle is reached.
  bit stub_en = 1'b1;
  int stub_n = 29;
  int s1_cnt, s2_cnt;

  // Reference model state.
  logic [7:0] ld_bytes [25];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int act1_n = 0, clr1_n = 0, err1_n = 0, err2_n = 0, in1_n = 0;
  logic [8:0] oq1[$];
  logic [8:0] oq2[$];
  int         ocyc1[$];

  always #5 clk = ~clk;

  sa2_host u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_last(out_last1),
    .err(err1), .sa_clr(sa_clr1), .active_sa2(act1), .done_sa2(done1),
    .a11(op1[0]), .a12(op1[1]), .a13(op1[2]), .a14(op1[3]),
    .a21(op1[4]), .a22(op1[5]), .a23(op1[6]), .a24(op1[7]),
    .a31(op1[8]), .a32(op1[9]), .a33(op1[10]), .a34(op1[11]),
    .a41(op1[12]), .a42(op1[13]), .a43(op1[14]), .a44(op1[15]),
    .b11(op1[16]), .b12(op1[17]), .b13(op1[18]),
    .b21(op1[19]), .b22(op1[20]), .b23(op1[21]),
    .b31(op1[22]), .b32(op1[23]), .b33(op1[24]),
    .c11(c_val[0]), .c12(c_val[1]), .c21(c_val[2]), .c22(c_val[3])
  );

  sa2_host #(.TIMEOUT(29)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_last(out_last2),
    .err(err2), .sa_clr(sa_clr2), .active_sa2(act2), .done_sa2(done2),
    .a11(op2[0]), .a12(op2[1]), .a13(op2[2]), .a14(op2[3]),
    .a21(op2[4]), .a22(op2[5]), .a23(op2[6]), .a24(op2[7]),
    .a31(op2[8]), .a32(op2[9]), .a33(op2[10]), .a34(op2[11]),
    .a41(op2[12]), .a42(op2[13]), .a43(op2[14]), .a44(op2[15]),
    .b11(op2[16]), .b12(op2[17]), .b13(op2[18]),
    .b21(op2[19]), .b22(op2[20]), .b23(op2[21]),
    .b31(op2[22]), .b32(op2[23]), .b33(op2[24]),
    .c11(c_val[0]), .c12(c_val[1]), .c21(c_val[2]), .c22(c_val[3])
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_cnt <= 0;
    else if (sa_clr1) s1_cnt <= 0;
    else if (act1) s1_cnt <= s1_cnt + 1;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) s2_cnt <= 0;
    else if (sa_clr2) s2_cnt <= 0;
    else if (act2) s2_cnt <= s2_cnt + 1;
  end
  assign done1 = stub_en && act1 && (s1_cnt == stub_n - 1);
  assign done2 = stub_en && act2 && (s2_cnt == stub_n - 1);

  // Event monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (act1) act1_n++;
    if (sa_clr1) clr1_n++;
    if (err1) err1_n++;
    if (err2) err2_n++;
    if (in_valid && in_ready1) in1_n++;
    if (out_valid1 && out_ready) begin
      oq1.push_back({out_last1, out_data1});
      ocyc1.push_back(cyc);
    end
    if (out_valid2 && out_ready) oq2.push_back({out_last2, out_data2});
    cyc++;
  end

  function automatic logic [199:0] pack(input logic [7:0] o [25]);
    logic [199:0] v = '0;
    for (int i = 0; i < 25; i++) v[i*8 +: 8] = o[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input bit toggle);
    for (int i = 0; i < 25; i++) begin
      in_valid = 1'b1;
      in_data  = ld_bytes[i];
      step();
      if (toggle && i < 24) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        step();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic rand_bytes();
    for (int i = 0; i < 25; i++) ld_bytes[i] = 8'($urandom);
  endtask

  task automatic rand_c();
    for (int i = 0; i < 4; i++) c_val[i] = 8'($urandom);
  endtask

  // Waits for DRAIN, optionally stalls, then checks the four result bytes and run statistics.
  task automatic run_drain(input int stall, input int exp_act, input int a0, input int k0);
    int o0 = oq1.size();
    int o20 = oq2.size();
    int e0 = err1_n;
    int e20 = err2_n;
    int n = 0;
    out_ready = (stall == 0);
    while (!out_valid1 && n < 300) begin step(); n++; end
    chk("drain_entered", out_valid1, 1'b1);
    chk("operands_stable", pack(op1), pack(ld_bytes));
    for (int s = 0; s < stall; s++) begin
      chk("stall_valid", out_valid1, 1'b1);
      chk("stall_data", out_data1, c_val[0]);
      step();
    end
    out_ready = 1'b1;
    n = 0;
    while (oq1.size() - o0 < 4 && n < 20) begin step(); n++; end
    chk("out_count", oq1.size() - o0, 4);
    chk("back_in_load", in_ready1, 1'b1);
    chk("out_valid_low", out_valid1, 1'b0);
    if (oq1.size() - o0 >= 4) begin
      for (int i = 0; i < 4; i++) chk("out_byte", oq1[o0 + i], {(i == 3), c_val[i]});
      if (stall == 0) chk("out_consecutive", ocyc1[o0 + 3] - ocyc1[o0], 3);
    end
    chk("active_cycles", act1_n - a0, exp_act);
    chk("clr_pulses", clr1_n - k0, 1);
    chk("no_err", err1_n - e0, 0);
    chk("t29_out_count", oq2.size() - o20, 4);
    if (oq2.size() - o20 >= 4)
      for (int i = 0; i < 4; i++) chk("t29_out_byte", oq2[o20 + i], {(i == 3), c_val[i]});
    chk("t29_no_err", err2_n - e20, 0);
  endtask

  initial begin
    int a0, k0, i0, e0, o0, n;
    c_val[0] = 8'h11; c_val[1] = 8'h22; c_val[2] = 8'h33; c_val[3] = 8'h44;

    // Reset state.
    #2;
    chk("rst_in_ready", in_ready1, 1'b1);
    chk("rst_outs", {out_valid1, out_last1, err1, sa_clr1, act1, out_data1}, '0);
    chk("rst_operands", pack(op1), '0);
    #20 rst_n = 1'b1;
    step();

    // Back-to-back load of 1..25.
    for (int i = 0; i < 25; i++) ld_bytes[i] = 8'(i + 1);
    a0 = act1_n; k0 = clr1_n;
    load(1'b0);
    chk("a11", op1[0], 8'd1);
    chk("a44", op1[15], 8'd16);
    chk("b11", op1[16], 8'd17);
    chk("b33", op1[24], 8'd25);
    chk("clr_after_load", {sa_clr1, in_ready1}, 2'b10);
    run_drain(0, 29, a0, k0);

    // Load with in_valid toggling; same bytes.
    rand_c();
    a0 = act1_n; k0 = clr1_n; i0 = in1_n;
    load(1'b1);
    chk("toggle_transfers", in1_n - i0, 25);
    chk("toggle_operands", pack(op1), pack(ld_bytes));
    chk("toggle_clr_next", {sa_clr1, in_ready1}, 2'b10);
    run_drain(0, 29, a0, k0);

    // Random operands, stalled drain.
    rand_bytes(); rand_c();
    a0 = act1_n; k0 = clr1_n;
    load(1'b0);
    run_drain(3, 29, a0, k0);

    // Timeout: stub never completes.
    stub_en = 1'b0;
    rand_bytes();
    a0 = act1_n; e0 = err1_n; o0 = oq1.size();
    load(1'b0);
    n = 0;
    while (!err1 && n < 300) begin step(); n++; end
    chk("timeout_err", err1, 1'b1);
    chk("timeout_in_ready", in_ready1, 1'b1);
    step();
    chk("timeout_err_pulse", err1, 1'b0);
    chk("timeout_err_count", err1_n - e0, 1);
    chk("timeout_active", act1_n - a0, 64);
    chk("timeout_no_out", oq1.size() - o0, 0);
    stub_en = 1'b1;

    // Reset in the middle of RUN, then a clean full run.
    rand_bytes();
    a0 = act1_n;
    load(1'b0);
    n = 0;
    while (act1_n - a0 < 10 && n < 100) begin step(); n++; end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outs", {act1, sa_clr1, out_valid1, err1}, 4'b0);
    chk("midrst_in_ready", in_ready1, 1'b1);
    chk("midrst_operands", pack(op1), '0);
    step();
    rst_n = 1'b1;
    step();
    rand_bytes(); rand_c();
    a0 = act1_n; k0 = clr1_n;
    load(1'b0);
    run_drain(0, 29, a0, k0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sa2_host.md
Name: sa2_host

Overview:
- Host-side driver for the 2x2 systolic convolution array.
- Accepts a byte stream over a valid/ready handshake: 16 data bytes (a11..a44, row-major) followed by 9 filter bytes (b11..b33, row-major). Holds these as stable matrix operands for the array.
- Clears the array, runs it with active_sa2 until done_sa2, captures c11..c22, then streams the four results out over valid/ready.
- Sits between the system byte bus and the array instance.

Parameters:
- TIMEOUT, 64, RUN-state cycle limit while waiting for done_sa2 (array nominally needs 29 cycles). Legal range 2..255.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input byte valid
- in_ready  output  1  host can accept a byte
- in_data  input  8  input byte
- out_valid  output  1  result byte valid
- out_ready  input  1  downstream accepts result byte
- out_data  output  8  result byte
- out_last  output  1  high with the final result byte (c22)
- err  output  1  one-cycle pulse on timeout
- sa_clr  output  1  active-high reset pulse to the array (clears accumulators)
- active_sa2  output  1  array run enable
- done_sa2  input  1  array completion (combinational from array)
- a11..a44  output  8 each  data matrix to array (16 ports)
- b11..b33  output  8 each  filter matrix to array (9 ports)
- c11, c12, c21, c22  input  8 each  array results

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = LOAD; all counters = 0.
  - All matrix and result registers = 0.
  - in_ready=1 (combinational from LOAD); out_valid=0, out_last=0, out_data=0, err=0, sa_clr=0, active_sa2=0.
- All control outputs are registered, except in_ready, out_valid, out_last and out_data, which decode state/index directly. No combinational path from in_valid or out_ready to any output.
- FSM states: LOAD, CLR, RUN, DRAIN.
- LOAD:
  - in_ready=1.
  - A byte transfers when in_valid && in_ready.
  - Byte index ld_cnt (5 bits, 0..24): 0..15 write a11,a12,a13,a14,a21..a44; 16..24 write b11..b33.
  - On the transfer with ld_cnt==24: ld_cnt->0, next state CLR.
  - With in_valid low, nothing changes.
- CLR:
  - in_ready=0; sa_clr=1 for exactly one cycle; next state RUN.
- RUN:
  - active_sa2=1 while in RUN; run counter increments each cycle from 0.
  - If done_sa2==1 at a clock edge: capture c11,c12,c21,c22 into result registers; active_sa2=0 from that edge on (the array must not see a second run); next state DRAIN.
  - Else if run counter == TIMEOUT-1: err=1 for one cycle; active_sa2=0; results not updated; next state LOAD.
  - If done and timeout coincide, done wins.
- DRAIN:
  - out_valid=1; out_data = result[rd_idx], order c11,c12,c21,c22.
  - out_last=1 when rd_idx==3.
  - On out_ready: rd_idx increments. On the transfer with rd_idx==3: rd_idx->0, next state LOAD.
  - out_data is stable while out_valid && !out_ready.
- Operand stability: a*/b* registers change only in LOAD, so they are constant throughout CLR, RUN and DRAIN. A new load may overwrite them after DRAIN completes.
- Results hold their last captured value until the next successful run.
- in_ready=0 outside LOAD. Input bytes presented then are ignored and not lost from the source (handshake stalls).
- Reset mid-operation (any state): immediate return to reset values. A partial load is discarded.
- done_sa2 outside RUN is ignored.

Test Plan:
- Bench uses a behavioural array stub that asserts done_sa2 for one cycle N cycles after active_sa2 rises and drives fixed c values; the stub clears its accumulators on sa_clr.
- Load bytes 1..25 back-to-back with stub N=29, c=(0x11,0x22,0x33,0x44), out_ready=1 -> a11=1, a44=16, b11=17, b33=25; sa_clr pulses once; active_sa2 high exactly 29 cycles then low; out_data 0x11,0x22,0x33,0x44 on consecutive cycles; out_last only with 0x44.
- Load with in_valid toggling every other cycle -> exactly 25 transfers; operand values identical to the back-to-back case; CLR entered one cycle after the 25th transfer.
- DRAIN with out_ready low 3 cycles, then high -> out_valid held, out_data=0x11 stable throughout; 4 transfers total; returns to LOAD with in_ready=1.
- Stub never asserts done, TIMEOUT=64 -> active_sa2 high 64 cycles; err single-cycle pulse; no out_valid; in_ready=1 next cycle; prior results unchanged.
- Assert rst_n low during RUN (cycle 10) -> active_sa2, sa_clr, out_valid and err all 0 immediately; a new full load and run completes normally.
- Stub asserts done on the same edge the timeout fires (TIMEOUT=29, N=29) -> results captured, no err, DRAIN entered.
